// File: rtl/lspc_timing_pkg.sv
// Shared LSPC raster timing constants and VMODE encoding.
// Used by the video timing block and the sprite/fix pipelines.
package lspc_timing_pkg;

    localparam logic [8:0] H_TOTAL     = 9'd384;
    localparam logic [8:0] H_ACTIVE    = 9'd320;
    localparam logic [8:0] HS_START    = 9'd336;
    localparam logic [8:0] HS_WIDTH    = 9'd28;
    localparam logic [8:0] RSTART_NTSC = 9'h0F8;
    localparam logic [8:0] RSTART_PAL  = 9'h0C8;
    localparam logic [8:0] VS_LINES    = 9'd8;
    localparam logic [8:0] V_ACT_FIRST = 9'h110;
    localparam logic [8:0] V_ACT_LAST  = 9'h1EF;
    localparam logic [8:0] RASTER_LAST = 9'h1FF;

    localparam logic VMODE_NTSC = 1'b0;
    localparam logic VMODE_PAL  = 1'b1;

    function automatic logic [8:0] frame_start(input logic pal,
                                               input logic [8:0] rstart_ntsc,
                                               input logic [8:0] rstart_pal);
        return (pal == VMODE_PAL) ? rstart_pal : rstart_ntsc;
    endfunction

endpackage

// File: rtl/lspc_hv_decode.sv
// Combinational sync/blank decode of the next pixel/raster counter values.
// The parent registers these so sync and blank move on the same edge as the counters.
module lspc_hv_decode
    import lspc_timing_pkg::*;
#(
    parameter logic [8:0] H_ACTIVE    = lspc_timing_pkg::H_ACTIVE,
    parameter logic [8:0] HS_START    = lspc_timing_pkg::HS_START,
    parameter logic [8:0] HS_WIDTH    = lspc_timing_pkg::HS_WIDTH,
    parameter logic [8:0] RSTART_NTSC = lspc_timing_pkg::RSTART_NTSC,
    parameter logic [8:0] RSTART_PAL  = lspc_timing_pkg::RSTART_PAL,
    parameter logic [8:0] VS_LINES    = lspc_timing_pkg::VS_LINES,
    parameter logic [8:0] V_ACT_FIRST = lspc_timing_pkg::V_ACT_FIRST,
    parameter logic [8:0] V_ACT_LAST  = lspc_timing_pkg::V_ACT_LAST
) (
    input  logic [8:0] pixelc_next,
    input  logic [8:0] rasterc_next,
    input  logic       pal_next,
    output logic       nhsync_next,
    output logic       chbl_next,
    output logic       nvsync_next,
    output logic       vblank_next
);

    localparam logic [8:0] HS_END = HS_START + HS_WIDTH;

    logic [8:0] vs_end;

    always_comb begin
        vs_end      = frame_start(pal_next, RSTART_NTSC, RSTART_PAL) + VS_LINES;
        nhsync_next = 1'b1;
        chbl_next   = 1'b0;
        nvsync_next = 1'b1;
        vblank_next = 1'b0;
        if ((pixelc_next >= HS_START) && (pixelc_next < HS_END)) begin
            nhsync_next = 1'b0;
        end
        if (pixelc_next >= H_ACTIVE) begin
            chbl_next = 1'b1;
        end
        if (rasterc_next < vs_end) begin
            nvsync_next = 1'b0;
        end
        if ((rasterc_next < V_ACT_FIRST) || (rasterc_next > V_ACT_LAST)) begin
            vblank_next = 1'b1;
        end
    end

endmodule

// File: rtl/lspc_video_timing.sv
// LSPC raster timing: pixel/line counters, registered sync/blank and enable-gated strobes.
// All progress is qualified by the 6 MHz pixel enable.
module lspc_video_timing
    import lspc_timing_pkg::*;
#(
    parameter logic [8:0] H_TOTAL     = lspc_timing_pkg::H_TOTAL,
    parameter logic [8:0] H_ACTIVE    = lspc_timing_pkg::H_ACTIVE,
    parameter logic [8:0] HS_START    = lspc_timing_pkg::HS_START,
    parameter logic [8:0] HS_WIDTH    = lspc_timing_pkg::HS_WIDTH,
    parameter logic [8:0] RSTART_NTSC = lspc_timing_pkg::RSTART_NTSC,
    parameter logic [8:0] RSTART_PAL  = lspc_timing_pkg::RSTART_PAL,
    parameter logic [8:0] VS_LINES    = lspc_timing_pkg::VS_LINES,
    parameter logic [8:0] V_ACT_FIRST = lspc_timing_pkg::V_ACT_FIRST,
    parameter logic [8:0] V_ACT_LAST  = lspc_timing_pkg::V_ACT_LAST
) (
    input  logic       CLK,
    input  logic       nRESETP,
    input  logic       CLK_EN_6MB,
    input  logic       VMODE,
    output logic [8:0] PIXELC,
    output logic [8:0] RASTERC,
    output logic       nHSYNC,
    output logic       nVSYNC,
    output logic       CHBL,
    output logic       VBLANK,
    output logic       nBNKB,
    output logic       LINE_EN,
    output logic       FRAME_EN,
    output logic       VBL_IRQ_EN
);

    logic [8:0] pixelc_q, pixelc_d;
    logic [8:0] rasterc_q, rasterc_d;
    logic       pal_q, pal_d;
    logic       nhsync_q, chbl_q, nvsync_q, vblank_q;
    logic       nhsync_d, chbl_d, nvsync_d, vblank_d;
    logic       pixel_last, raster_last;

    assign pixel_last  = (pixelc_q == H_TOTAL - 9'd1);
    assign raster_last = (rasterc_q == RASTER_LAST);

    always_comb begin
        pixelc_d  = pixelc_q;
        rasterc_d = rasterc_q;
        pal_d     = pal_q;
        if (CLK_EN_6MB) begin
            if (pixel_last) begin
                pixelc_d = '0;
                if (raster_last) begin
                    // Mode only takes effect at the frame boundary.
                    rasterc_d = frame_start(VMODE, RSTART_NTSC, RSTART_PAL);
                    pal_d     = VMODE;
                end else begin
                    rasterc_d = rasterc_q + 9'd1;
                end
            end else begin
                pixelc_d = pixelc_q + 9'd1;
            end
        end
    end

    lspc_hv_decode #(
        .H_ACTIVE    (H_ACTIVE),
        .HS_START    (HS_START),
        .HS_WIDTH    (HS_WIDTH),
        .RSTART_NTSC (RSTART_NTSC),
        .RSTART_PAL  (RSTART_PAL),
        .VS_LINES    (VS_LINES),
        .V_ACT_FIRST (V_ACT_FIRST),
        .V_ACT_LAST  (V_ACT_LAST)
    ) u_hv_decode (
        .pixelc_next  (pixelc_d),
        .rasterc_next (rasterc_d),
        .pal_next     (pal_d),
        .nhsync_next  (nhsync_d),
        .chbl_next    (chbl_d),
        .nvsync_next  (nvsync_d),
        .vblank_next  (vblank_d)
    );

    always_ff @(posedge CLK or negedge nRESETP) begin
        if (!nRESETP) begin
            pixelc_q  <= '0;
            rasterc_q <= RSTART_NTSC;
            pal_q     <= VMODE_NTSC;
            nhsync_q  <= 1'b1;
            chbl_q    <= 1'b0;
            nvsync_q  <= 1'b0;
            vblank_q  <= 1'b1;
        end else if (CLK_EN_6MB) begin
            pixelc_q  <= pixelc_d;
            rasterc_q <= rasterc_d;
            pal_q     <= pal_d;
            nhsync_q  <= nhsync_d;
            chbl_q    <= chbl_d;
            nvsync_q  <= nvsync_d;
            vblank_q  <= vblank_d;
        end
    end

    assign PIXELC     = pixelc_q;
    assign RASTERC    = rasterc_q;
    assign nHSYNC     = nhsync_q;
    assign CHBL       = chbl_q;
    assign nVSYNC     = nvsync_q;
    assign VBLANK     = vblank_q;
    assign nBNKB      = ~(chbl_q | vblank_q);
    assign LINE_EN    = CLK_EN_6MB & pixel_last;
    assign FRAME_EN   = LINE_EN & raster_last;
    assign VBL_IRQ_EN = LINE_EN & (rasterc_q == V_ACT_LAST);

endmodule

// File: tb/tb_lspc_video_timing.sv
// Directed bench for lspc_video_timing: a default-geometry instance plus a short-line
// instance (8-pixel lines) so whole NTSC/PAL frames fit in a short run.
module tb_lspc_video_timing;

    logic CLK = 1'b0;
    logic nRESETP = 1'b1;
    logic CLK_EN_6MB = 1'b0;
    logic VMODE = 1'b0;

    logic [8:0] d_pixelc, d_rasterc, s_pixelc, s_rasterc;
    logic d_nhsync, d_nvsync, d_chbl, d_vblank, d_nbnkb, d_line_en, d_frame_en, d_irq_en;
    logic s_nhsync, s_nvsync, s_chbl, s_vblank, s_nbnkb, s_line_en, s_frame_en, s_irq_en;

    int n_checks = 0;
    int n_fail = 0;

    // Reference state for each instance.
    int dp, dr, sp, sr;
    bit dpal, spal;
    bit chk_def = 0, chk_sml = 0;
    int tick_no, s_frame_at, n_s_frame, n_s_irq, n_s_vs, n_s_va, n_d_hs, n_d_chbl, n_d_line;

    always #5 CLK = ~CLK;

    lspc_video_timing u_dut (
        .CLK        (CLK),
        .nRESETP    (nRESETP),
        .CLK_EN_6MB (CLK_EN_6MB),
        .VMODE      (VMODE),
        .PIXELC     (d_pixelc),
        .RASTERC    (d_rasterc),
        .nHSYNC     (d_nhsync),
        .nVSYNC     (d_nvsync),
        .CHBL       (d_chbl),
        .VBLANK     (d_vblank),
        .nBNKB      (d_nbnkb),
        .LINE_EN    (d_line_en),
        .FRAME_EN   (d_frame_en),
        .VBL_IRQ_EN (d_irq_en)
    );

    lspc_video_timing #(
        .H_TOTAL  (9'd8),
        .H_ACTIVE (9'd5),
        .HS_START (9'd6),
        .HS_WIDTH (9'd1)
    ) u_dut_short (
        .CLK        (CLK),
        .nRESETP    (nRESETP),
        .CLK_EN_6MB (CLK_EN_6MB),
        .VMODE      (VMODE),
        .PIXELC     (s_pixelc),
        .RASTERC    (s_rasterc),
        .nHSYNC     (s_nhsync),
        .nVSYNC     (s_nvsync),
        .CHBL       (s_chbl),
        .VBLANK     (s_vblank),
        .nBNKB      (s_nbnkb),
        .LINE_EN    (s_line_en),
        .FRAME_EN   (s_frame_en),
        .VBL_IRQ_EN (s_irq_en)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit f_nh(int pix, int hs, int w);
        return !((pix >= hs) && (pix < hs + w));
    endfunction

    function automatic bit f_nv(int ras, bit pal);
        int first;
        first = pal ? 'h0C8 : 'h0F8;
        return !(ras < first + 8);
    endfunction

    function automatic bit f_vb(int ras);
        return (ras < 'h110) || (ras > 'h1EF);
    endfunction

    task automatic model_step(input int h, inout int pix, inout int ras, inout bit pal);
        if (pix == h - 1) begin
            pix = 0;
            if (ras == 'h1FF) begin
                pal = VMODE;
                ras = VMODE ? 'h0C8 : 'h0F8;
            end else begin
                ras = ras + 1;
            end
        end else begin
            pix = pix + 1;
        end
    endtask

    task automatic model_reset();
        dp = 0; dr = 'h0F8; dpal = 0;
        sp = 0; sr = 'h0F8; spal = 0;
    endtask

    task automatic check_def();
        bit ch, vb;
        ch = (dp >= 320);
        vb = f_vb(dr);
        check("d_pixelc", d_pixelc, dp);
        check("d_rasterc", d_rasterc, dr);
        check("d_nhsync", d_nhsync, f_nh(dp, 336, 28));
        check("d_chbl", d_chbl, ch);
        check("d_nvsync", d_nvsync, f_nv(dr, dpal));
        check("d_vblank", d_vblank, vb);
        check("d_nbnkb", d_nbnkb, !(ch || vb));
    endtask

    task automatic check_sml();
        bit ch, vb;
        ch = (sp >= 5);
        vb = f_vb(sr);
        check("s_pixelc", s_pixelc, sp);
        check("s_rasterc", s_rasterc, sr);
        check("s_nhsync", s_nhsync, f_nh(sp, 6, 1));
        check("s_chbl", s_chbl, ch);
        check("s_nvsync", s_nvsync, f_nv(sr, spal));
        check("s_vblank", s_vblank, vb);
        check("s_nbnkb", s_nbnkb, !(ch || vb));
    endtask

    task automatic check_reset_consts();
        check("rst_pixelc", d_pixelc, 0);
        check("rst_rasterc", d_rasterc, 'h0F8);
        check("rst_nvsync", d_nvsync, 0);
        check("rst_vblank", d_vblank, 1);
        check("rst_nbnkb", d_nbnkb, 0);
        check("rst_nhsync", d_nhsync, 1);
        check("rst_chbl", d_chbl, 0);
        check("rst_strobes", {d_line_en, d_frame_en, d_irq_en}, 0);
    endtask

    task automatic clear_counts();
        tick_no = 0; s_frame_at = -1;
        n_s_frame = 0; n_s_irq = 0; n_s_vs = 0; n_s_va = 0;
        n_d_hs = 0; n_d_chbl = 0; n_d_line = 0;
    endtask

    // Starts and ends just after a falling CLK edge; toggles the enable while in reset.
    task automatic apply_reset();
        nRESETP = 1'b0;
        #1;
        model_reset();
        check_reset_consts();
        for (int i = 0; i < 4; i++) begin
            CLK_EN_6MB = ~CLK_EN_6MB;
            @(negedge CLK);
            #1;
            check_reset_consts();
            check_sml();
        end
        CLK_EN_6MB = 1'b0;
        nRESETP = 1'b1;
    endtask

    // One pixel enable followed by idle cycles in which everything must hold.
    task automatic tick(input int idle);
        bit el_d, ef_d, ei_d, el_s, ef_s, ei_s;
        CLK_EN_6MB = 1'b1;
        #1;
        el_d = (dp == 383); ef_d = el_d && (dr == 'h1FF); ei_d = el_d && (dr == 'h1EF);
        el_s = (sp == 7);   ef_s = el_s && (sr == 'h1FF); ei_s = el_s && (sr == 'h1EF);
        if (chk_def) begin
            check("d_line_en", d_line_en, el_d);
            check("d_frame_en", d_frame_en, ef_d);
            check("d_vbl_irq_en", d_irq_en, ei_d);
        end
        if (chk_sml) begin
            check("s_line_en", s_line_en, el_s);
            check("s_frame_en", s_frame_en, ef_s);
            check("s_vbl_irq_en", s_irq_en, ei_s);
        end
        n_d_line += int'(d_line_en);
        n_s_frame += int'(s_frame_en);
        n_s_irq += int'(s_irq_en);
        if (s_frame_en) s_frame_at = tick_no;
        tick_no++;
        model_step(384, dp, dr, dpal);
        model_step(8, sp, sr, spal);
        @(negedge CLK);
        CLK_EN_6MB = 1'b0;
        #1;
        if (chk_def) check_def();
        if (chk_sml) check_sml();
        if (!d_nhsync) n_d_hs++;
        if (d_chbl) n_d_chbl++;
        if (!s_nvsync) n_s_vs++;
        if (!s_vblank) n_s_va++;
        for (int i = 0; i < idle; i++) begin
            @(negedge CLK);
            #1;
            if (chk_def) begin
                check_def();
                check("d_strobe_idle", {d_line_en, d_frame_en, d_irq_en}, 0);
            end
            if (chk_sml) begin
                check_sml();
                check("s_strobe_idle", {s_line_en, s_frame_en, s_irq_en}, 0);
            end
        end
    endtask

    task automatic check_frame(input string tag, input int len, input int ras0);
        check({tag, "_frame_cnt"}, n_s_frame, 1);
        check({tag, "_frame_at"}, s_frame_at, len - 1);
        check({tag, "_irq_cnt"}, n_s_irq, 1);
        check({tag, "_vsync_pix"}, n_s_vs, 64);
        check({tag, "_active_pix"}, n_s_va, 1792);
        check({tag, "_end_rasterc"}, s_rasterc, ras0);
        check({tag, "_end_pixelc"}, s_pixelc, 0);
    endtask

    initial begin
        #3;
        apply_reset();

        // One NTSC line with 3 idle cycles after every enable.
        clear_counts();
        chk_def = 1;
        for (int i = 0; i < 384; i++) tick(3);
        check("line_hsync_pix", n_d_hs, 28);
        check("line_chbl_pix", n_d_chbl, 64);
        check("line_en_cnt", n_d_line, 1);
        check("line_wrap_pixelc", d_pixelc, 0);
        check("line_wrap_rasterc", d_rasterc, 'h0F9);
        chk_def = 0;

        // Whole NTSC frame on the short-line instance.
        apply_reset();
        chk_sml = 1;
        clear_counts();
        for (int i = 0; i < 264 * 8; i++) tick(0);
        check_frame("ntsc", 264 * 8, 'h0F8);

        // VMODE goes to PAL mid-frame: this frame stays NTSC length.
        clear_counts();
        for (int i = 0; i < 1000; i++) tick(0);
        VMODE = 1'b1;
        for (int i = 0; i < 264 * 8 - 1000; i++) tick(0);
        check_frame("switch", 264 * 8, 'h0C8);

        clear_counts();
        for (int i = 0; i < 312 * 8; i++) tick(0);
        check_frame("pal", 312 * 8, 'h0C8);

        // Random enable gaps across a full PAL frame.
        clear_counts();
        for (int i = 0; i < 312 * 8; i++) tick($urandom_range(0, 10));
        check_frame("gap", 312 * 8, 'h0C8);
        chk_sml = 0;

        // Reset in the middle of a frame.
        VMODE = 1'b0;
        apply_reset();
        for (int i = 0; i < 88 * 384 + 200; i++) tick(0);
        check("mid_pixelc", d_pixelc, 200);
        check("mid_rasterc", d_rasterc, 'h150);
        #2;
        apply_reset();
        chk_def = 1;
        tick(0);
        check("post_rst_pixelc", d_pixelc, 1);
        check("post_rst_rasterc", d_rasterc, 'h0F8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lspc_video_timing.md
Name: lspc_video_timing

Overview:
- Downstream consumer of the clock-enable generator; derives all raster timing from the 6 MHz pixel enable (CLK_EN_6MB).
- Produces the pixel/raster counters, sync, blanking, and line/frame/IRQ strobes for the sprite, fix, palette and interrupt logic.
- Single clock domain (CLK); all progress is gated by CLK_EN_6MB.

Parameters:
- H_TOTAL, 384: pixels per line; PIXELC runs 0..H_TOTAL-1.
- H_ACTIVE, 320: visible pixels, PIXELC 0..H_ACTIVE-1.
- HS_START, 336: first PIXELC with nHSYNC low.
- HS_WIDTH, 28: nHSYNC low width in pixels.
- RSTART_NTSC, 9'h0F8: first RASTERC of an NTSC frame (264 lines).
- RSTART_PAL, 9'h0C8: first RASTERC of a PAL frame (312 lines).
- VS_LINES, 8: lines with nVSYNC low, counted from frame start.
- V_ACT_FIRST, 9'h110: first visible line.
- V_ACT_LAST, 9'h1EF: last visible line.

Ports:
- CLK  in  1  system clock.
- nRESETP  in  1  reset, asynchronous, active-low.
- CLK_EN_6MB  in  1  pixel enable, one CLK cycle per pixel.
- VMODE  in  1  0=NTSC, 1=PAL; sampled only at frame wrap.
- PIXELC  out  9  horizontal pixel counter.
- RASTERC  out  9  line counter; last line is always 9'h1FF.
- nHSYNC  out  1  horizontal sync, active low.
- nVSYNC  out  1  vertical sync, active low.
- CHBL  out  1  horizontal blank, active high.
- VBLANK  out  1  vertical blank, active high.
- nBNKB  out  1  combined blank, active low: ~(CHBL|VBLANK).
- LINE_EN  out  1  strobe: CLK_EN_6MB & PIXELC==H_TOTAL-1.
- FRAME_EN  out  1  strobe: LINE_EN & RASTERC==9'h1FF.
- VBL_IRQ_EN  out  1  strobe: LINE_EN & RASTERC==V_ACT_LAST.

Behaviour:
- Reset (async, nRESETP=0):
  - PIXELC=0, RASTERC=RSTART_NTSC, internal PAL flag=0.
  - nHSYNC=1, CHBL=0, nVSYNC=0, VBLANK=1, nBNKB=0.
  - Strobes are combinational from the counters, so they read 0 while CLK_EN_6MB=0.
- Counters advance only on CLK edges with CLK_EN_6MB=1. With CLK_EN_6MB=0, every registered output holds, regardless of gap length.
- PIXELC: increments; at H_TOTAL-1 it wraps to 0 and RASTERC advances on the same edge.
- RASTERC: increments; at 9'h1FF it wraps to VMODE ? RSTART_PAL : RSTART_NTSC, and the PAL flag loads VMODE on that same edge. A VMODE change mid-frame has no effect until the next wrap.
- Sync/blank outputs are registered decodes of the next counter values, so they change on the same edge as the counters with zero skew. No one-pixel lag is allowed.
- nHSYNC=0 iff HS_START <= PIXELC < HS_START+HS_WIDTH.
- CHBL=1 iff PIXELC >= H_ACTIVE.
- nVSYNC=0 iff RASTERC < frame_start+VS_LINES, where frame_start comes from the PAL flag.
- VBLANK=1 iff RASTERC < V_ACT_FIRST or RASTERC > V_ACT_LAST.
- Strobes:
  - Pure combinational AND of CLK_EN_6MB with the current counter compare; high for exactly one CLK cycle.
  - FRAME_EN and LINE_EN coincide on the frame's last pixel.
  - VBL_IRQ_EN fires once per frame in both modes.
- Width rules:
  - 9-bit unsigned compares only.
  - PIXELC never exceeds H_TOTAL-1.
  - RASTERC never falls below the active frame_start.
- Reset mid-line or mid-frame: immediate return to reset values. First CLK_EN_6MB after release gives PIXELC=1, RASTERC=RSTART_NTSC.

Decomposition:
- Package lspc_timing_pkg holds the default constants (H_TOTAL, H_ACTIVE, HS_*, RSTART_*, V_ACT_*, VS_LINES) and the VMODE encoding (VMODE_NTSC=0, VMODE_PAL=1). The sprite/fix pipelines share these constants.
- Natural sub-module: lspc_hv_decode, combinational; maps next PIXELC/RASTERC/PAL flag to next sync/blank values. It is instanced once; its outputs are registered in the parent.

Test Plan:
- Reset: hold nRESETP=0, toggle CLK_EN_6MB
  -> PIXELC=0, RASTERC=0x0F8, nVSYNC=0, VBLANK=1, nBNKB=0, nHSYNC=1, all strobes 0.
- One line NTSC: 384 enables, each followed by 3 idle CLK cycles
  -> nHSYNC low exactly for PIXELC 336..363; CHBL high for 320..383.
  -> LINE_EN one cycle at PIXELC=383; PIXELC wraps to 0 and RASTERC=0x0F9 on the same edge.
- Full NTSC frame: 264*384=101376 enables
  -> exactly one FRAME_EN and one VBL_IRQ_EN (at RASTERC=0x1EF, PIXELC=383).
  -> nVSYNC low for lines 0x0F8..0x0FF; VBLANK low only for 0x110..0x1EF.
- PAL switch: set VMODE=1 mid-frame
  -> current frame still 264 lines; next frame starts at RASTERC=0x0C8 and lasts 312 lines; nVSYNC low for 0x0C8..0x0CF.
- Enable gaps: random CLK_EN_6MB duty (0-10 idle cycles)
  -> all counters/outputs hold in gaps; strobe count per frame unchanged.
- Reset mid-operation: assert nRESETP at PIXELC=200, RASTERC=0x150
  -> immediate reset values; after release, first enable gives PIXELC=1, RASTERC=0x0F8.
